rr_onehot_arbiter: RTL and testbench
====================================

Name: rr_onehot_arbiter

Overview:
Round-robin arbiter that shares one downstream resource (such as a sequenced one-hot FSM datapath) between N requesters. Grants are one-hot. Each grant is held until the owner signals done, withdraws its request, or hits a hold timeout. The controller is a one-hot FSM with a rotating one-hot priority pointer. It sits between requesting agents and the shared resource's start/enable inputs.

Parameters:
N, 4, number of requesters (2..8)
TIMEOUT, 16, maximum grant length in cycles; 0 disables the timeout
CW, 5, width of the hold counter; must satisfy 2^CW > TIMEOUT

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  N  per-requester request level
done  input  N  per-requester completion pulse; only the bit of the current owner is honoured
gnt  output  N  registered one-hot grant; all zero when no owner
gnt_id  output  clog2(N)  binary index of the owner; valid when gnt_valid=1
gnt_valid  output  1  high when any gnt bit is set
timeout_pulse  output  1  one-cycle pulse when a grant is revoked by timeout
state  output  3  one-hot FSM state for debug: IDLE=001, GRANT=010, RELEASE=100

Behaviour:
- Reset (asynchronous, any cycle, including mid-grant):
  - gnt=0, gnt_id=0, gnt_valid=0, timeout_pulse=0
  - state=IDLE, priority pointer ptr=one-hot bit 0, hold counter=0
- Arbitration function:
  - Winner = first set req bit found by scanning from ptr upward, wrapping modulo N.
  - The result is registered, so gnt appears 1 cycle after req is sampled.
- IDLE:
  - If req!=0 → GRANT next cycle, with gnt=winner, gnt_id=its index, counter=0.
  - Otherwise stay in IDLE.
- GRANT, owner i:
  - gnt is held constant and the counter increments each cycle.
  - Release when any of the following holds:
    - (a) done[i]=1
    - (b) req[i]=0
    - (c) TIMEOUT!=0 and counter==TIMEOUT-1
  - On release, next cycle:
    - state=RELEASE, gnt=0, gnt_valid=0
    - ptr=rotate-left of gnt (priority goes to i+1 mod N)
  - timeout_pulse=1 in that RELEASE cycle only, and only if (c) caused the release.
  - Priority when conditions coincide: done or req-drop wins over timeout, and no timeout_pulse is generated.
  - done bits of non-owners are ignored in every state.
- RELEASE (one bubble cycle, gnt=0):
  - Arbitrates with the updated ptr.
  - If req!=0 → GRANT next cycle; otherwise → IDLE.
  - Result: back-to-back owners are separated by exactly one gnt=0 cycle.
- Grant duration:
  - Maximum is TIMEOUT cycles.
  - Minimum is 1 cycle (req dropped or done in the first GRANT cycle).
- Fairness: under continuous all-ones req, grants rotate 0,1,...,N-1,0. No requester waits more than N grants.
- Illegal or non-one-hot state register → IDLE on the next clock, with gnt=0.
- gnt_id and gnt_valid are derived from registered gnt, so they carry no extra latency.

Test Plan:
- Async reset asserted mid-cycle while gnt=0010 → gnt=0, gnt_valid=0, state=001 immediately, without waiting for a clock. After release, req=0001 → gnt=0001 one cycle later.
- req=0100 from cycle t, done[2] pulse at t+3 → gnt=0100/gnt_id=2 for t+1..t+3, gnt=0 and state=100 at t+4, state=001 at t+5.
- req=1111 held, each owner pulses done on its 2nd grant cycle → grant order 0,1,2,3,0, with exactly one gnt=0 cycle between owners.
- TIMEOUT=16, req=0011 held, no done → gnt=0001 for exactly 16 cycles, then timeout_pulse=1 with gnt=0, then gnt=0010. Repeat with done[0] on the 16th cycle → no timeout_pulse.
- Owner 1 drops req[1] mid-grant while done[3]=1 is pulsed by non-owner 3 → done[3] is ignored, gnt drops on the cycle after req[1] falls, and the next grant goes to 2 if req[2]=1.
- Force state=011 via the bench → state=001 and gnt=0 on the next clock.

Source files
------------

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with one-hot grants, a rotating one-hot priority pointer
// and a per-grant hold timeout. Grants are registered; one bubble cycle separates owners.
module rr_onehot_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 gnt_valid,
    output logic                 timeout_pulse,
    output logic [2:0]           state
);
    localparam int IW = $clog2(N);
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b001,
        S_GRANT   = 3'b010,
        S_RELEASE = 3'b100
    } state_t;

    // Kept as plain bits so a corrupted, non-one-hot value is representable and recoverable.
    logic [2:0]    r_state;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  r_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_timeout_pulse;

    logic [N-1:0]  w_req_hi;
    logic [N-1:0]  w_win_hi;
    logic [N-1:0]  w_win_lo;
    logic [N-1:0]  w_win;
    logic [N-1:0]  w_ptr_rot;
    logic          w_own_done;
    logic          w_own_req;
    logic          w_to_hit;
    logic [IW-1:0] w_id;

    // Requests at or above the pointer take precedence; otherwise wrap to the lowest set bit.
    assign w_req_hi = req & ~(r_ptr - N'(1));
    assign w_win_hi = w_req_hi & (~w_req_hi + N'(1));
    assign w_win_lo = req & (~req + N'(1));
    assign w_win    = (|w_req_hi) ? w_win_hi : w_win_lo;

    assign w_ptr_rot  = {r_gnt[N-2:0], r_gnt[N-1]};
    assign w_own_done = |(done & r_gnt);
    assign w_own_req  = |(req & r_gnt);
    assign w_to_hit   = TO_EN && (r_cnt == TO_LAST);

    always_comb begin
        w_id = '0;
        for (int i = 0; i < N; i++) begin
            if (r_gnt[i]) begin
                w_id = w_id | IW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_gnt           <= '0;
            r_ptr           <= N'(1);
            r_cnt           <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= 1'b0;
            case (r_state)
                S_IDLE, S_RELEASE: begin
                    r_cnt <= '0;
                    if (|req) begin
                        r_state <= S_GRANT;
                        r_gnt   <= w_win;
                    end else begin
                        r_state <= S_IDLE;
                        r_gnt   <= '0;
                    end
                end
                S_GRANT: begin
                    if (w_own_done || !w_own_req || w_to_hit) begin
                        r_state         <= S_RELEASE;
                        r_gnt           <= '0;
                        r_ptr           <= w_ptr_rot;
                        // Done or request withdrawal takes precedence over a coincident timeout.
                        r_timeout_pulse <= w_to_hit && !w_own_done && w_own_req;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign gnt           = r_gnt;
    assign gnt_id        = w_id;
    assign gnt_valid     = |r_gnt;
    assign timeout_pulse = r_timeout_pulse;
    assign state         = r_state;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter: stimulus pushes cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rr_onehot_arbiter;
    localparam int N       = 4;
    localparam int TIMEOUT = 16;
    localparam int CW      = 5;
    localparam logic [2:0] ST_IDLE  = 3'b001;
    localparam logic [2:0] ST_GRANT = 3'b010;
    localparam logic [2:0] ST_REL   = 3'b100;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req   = '0;
    logic [N-1:0] done  = '0;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         gnt_valid;
    logic         timeout_pulse;
    logic [2:0]   state;

    rr_onehot_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .done          (done),
        .gnt           (gnt),
        .gnt_id        (gnt_id),
        .gnt_valid     (gnt_valid),
        .timeout_pulse (timeout_pulse),
        .state         (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int           cyc;
        logic [N-1:0] gnt;
        logic         tp;
        logic [2:0]   st;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, want %0h", name, cyc, act, want);
        end
    endtask

    // Expected output for the cycle dc clocks from now; kept sorted by cycle tag.
    task automatic push_exp(input int dc, input logic [N-1:0] g, input logic tp, input logic [2:0] st);
        exp_t e;
        int   i;
        e.cyc = cyc + dc;
        e.gnt = g;
        e.tp  = tp;
        e.st  = st;
        i = exp_q.size();
        while (i > 0 && exp_q[i-1].cyc > e.cyc) i--;
        exp_q.insert(i, e);
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        oh_idx = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) oh_idx = i;
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        push_exp(1, '0, 1'b0, ST_IDLE);
        tick(1);
        reset = 1'b0;
        push_exp(1, '0, 1'b0, ST_IDLE);
        tick(1);
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    // Monitor: compare every expectation whose cycle has arrived.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                $display("cycle %0d: gnt=%b id=%0d valid=%b tp=%b state=%b", cyc, gnt, gnt_id, gnt_valid, timeout_pulse, state);
                chk("gnt", 32'(gnt), 32'(e.gnt));
                chk("gnt_valid", 32'(gnt_valid), 32'(|e.gnt));
                if (e.gnt != '0) chk("gnt_id", 32'(gnt_id), 32'(oh_idx(e.gnt)));
                chk("timeout_pulse", 32'(timeout_pulse), 32'(e.tp));
                chk("state", 32'(state), 32'(e.st));
            end
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded time budget");
        summary();
        $finish;
    end

    initial begin
        logic [N-1:0] g;

        // Reset held, then released with no requests.
        tick(1);
        push_exp(1, '0, 1'b0, ST_IDLE);
        tick(1);
        reset = 1'b0;
        push_exp(1, '0, 1'b0, ST_IDLE);
        tick(1);

        // Asynchronous reset in the middle of a grant to requester 1.
        req = 4'b0010;
        push_exp(1, 4'b0010, 1'b0, ST_GRANT);
        tick(1);
        #2 reset = 1'b1;
        #1;
        chk("async_gnt", 32'(gnt), 32'd0);
        chk("async_valid", 32'(gnt_valid), 32'd0);
        chk("async_state", 32'(state), 32'(ST_IDLE));
        chk("async_tp", 32'(timeout_pulse), 32'd0);
        tick(1);
        req   = '0;
        reset = 1'b0;
        push_exp(1, '0, 1'b0, ST_IDLE);
        tick(1);
        req = 4'b0001;
        push_exp(1, 4'b0001, 1'b0, ST_GRANT);
        tick(1);
        req = '0;
        push_exp(1, '0, 1'b0, ST_REL);
        push_exp(2, '0, 1'b0, ST_IDLE);
        tick(2);

        // Single requester 2 released by its done pulse in the third grant cycle.
        req = 4'b0100;
        for (int d = 1; d <= 3; d++) push_exp(d, 4'b0100, 1'b0, ST_GRANT);
        push_exp(4, '0, 1'b0, ST_REL);
        push_exp(5, '0, 1'b0, ST_IDLE);
        tick(3);
        done = 4'b0100;
        tick(1);
        done = '0;
        req  = '0;
        tick(2);

        // All requesting: rotation 0,1,2,3,0 with one bubble between owners.
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            g = N'(1) << (k % N);
            push_exp(1 + 3*k, g, 1'b0, ST_GRANT);
            push_exp(2 + 3*k, g, 1'b0, ST_GRANT);
            push_exp(3 + 3*k, '0, 1'b0, ST_REL);
        end
        push_exp(16, '0, 1'b0, ST_IDLE);
        for (int k = 0; k < 5; k++) begin
            tick(2);
            done = N'(1) << (k % N);
            if (k == 4) req = '0;
            tick(1);
            done = '0;
        end
        tick(1);

        // Timeout: owner 0 held 16 cycles, pulse on revoke, then owner 1.
        do_reset();
        req = 4'b0011;
        for (int d = 1; d <= 16; d++) push_exp(d, 4'b0001, 1'b0, ST_GRANT);
        push_exp(17, '0, 1'b1, ST_REL);
        push_exp(18, 4'b0010, 1'b0, ST_GRANT);
        push_exp(19, '0, 1'b0, ST_REL);
        push_exp(20, '0, 1'b0, ST_IDLE);
        tick(18);
        req = '0;
        tick(2);

        // Done coinciding with the timeout cycle suppresses the pulse.
        do_reset();
        req = 4'b0011;
        for (int d = 1; d <= 16; d++) push_exp(d, 4'b0001, 1'b0, ST_GRANT);
        push_exp(17, '0, 1'b0, ST_REL);
        push_exp(18, 4'b0010, 1'b0, ST_GRANT);
        push_exp(19, '0, 1'b0, ST_REL);
        push_exp(20, '0, 1'b0, ST_IDLE);
        tick(16);
        done = 4'b0001;
        tick(1);
        done = '0;
        tick(1);
        req = '0;
        tick(2);

        // Non-owner done ignored; owner 1 drops request, next grant goes to 2.
        do_reset();
        req = 4'b0010;
        push_exp(1, 4'b0010, 1'b0, ST_GRANT);
        push_exp(2, 4'b0010, 1'b0, ST_GRANT);
        push_exp(3, '0, 1'b0, ST_REL);
        push_exp(4, 4'b0100, 1'b0, ST_GRANT);
        push_exp(5, '0, 1'b0, ST_REL);
        push_exp(6, '0, 1'b0, ST_IDLE);
        tick(1);
        req  = 4'b0110;
        done = 4'b1000;
        tick(1);
        req = 4'b0100;
        tick(1);
        done = '0;
        tick(1);
        req = '0;
        tick(2);

        // Corrupted state register recovers to IDLE with no grant.
        req = 4'b0001;
        push_exp(1, 4'b0001, 1'b0, ST_GRANT);
        tick(1);
        force dut.r_state = 3'b011;
        #1 release dut.r_state;
        req = '0;
        push_exp(1, '0, 1'b0, ST_IDLE);
        push_exp(2, '0, 1'b0, ST_IDLE);
        tick(2);

        tick(2);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        summary();
        $finish;
    end

endmodule
